// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - benchmark performance counters with WFI freeze and req/ack read port
module perf_counter_unit #(
    parameter int CYC_W    = 64,
    parameter int EVT_W    = 20,
    parameter int COMMIT_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic [COMMIT_W-1:0] commit_cnt_i,
    input  logic [COMMIT_W-1:0] branch_cnt_i,
    input  logic                mispredict_i,
    input  logic                wfi_i,
    input  logic                rd_req_i,
    input  logic [2:0]          rd_addr_i,
    output logic                rd_ack_o,
    output logic [31:0]         rd_data_o,
    output logic                frozen_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [EVT_W-1:0] instr_q, instr_d;
    logic [EVT_W-1:0] branch_q, branch_d;
    logic [EVT_W-1:0] mispr_q, mispr_d;
    logic [31:0]      hi_q, hi_d;
    logic             frozen_q, frozen_d;
    logic             rd_ack_q, rd_ack_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic [63:0]      cyc_ext;
    logic [31:0]      rd_mux;
    logic             count_en;
    logic             rd_accept;

    // Clamp to all-ones instead of wrapping when the add carries out.
    function automatic logic [EVT_W-1:0] sat_add(input logic [EVT_W-1:0] a,
                                                 input logic [EVT_W-1:0] b);
        logic [EVT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[EVT_W] ? {EVT_W{1'b1}} : s[EVT_W-1:0];
    endfunction

    assign cyc_ext   = 64'(cycle_q);
    assign count_en  = (state_q == ST_RUN) && enable_i;
    assign rd_accept = rd_req_i && !rd_ack_q;

    always_comb begin
        rd_mux = 32'd0;
        case (rd_addr_i)
            3'd0:    rd_mux = cyc_ext[31:0];
            3'd1:    rd_mux = hi_q;
            3'd2:    rd_mux = 32'(instr_q);
            3'd3:    rd_mux = 32'(branch_q);
            3'd4:    rd_mux = 32'(mispr_q);
            3'd5:    rd_mux = {29'd0, frozen_q, state_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        branch_d  = branch_q;
        mispr_d   = mispr_q;
        hi_d      = hi_q;
        rd_ack_d  = rd_accept;
        rd_data_d = rd_accept ? rd_mux : 32'd0;

        case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_RUN;
            ST_RUN:    if (wfi_i) state_d = ST_FROZEN;
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase

        // Events in the WFI cycle still count; the freeze takes effect afterwards.
        if (count_en) begin
            cycle_d  = cycle_q + CYC_W'(1);
            instr_d  = sat_add(instr_q, EVT_W'(commit_cnt_i));
            branch_d = sat_add(branch_q, EVT_W'(branch_cnt_i));
            mispr_d  = sat_add(mispr_q, EVT_W'(mispredict_i));
        end

        if (rd_accept && rd_addr_i == 3'd0) hi_d = cyc_ext[63:32];

        // Clear wins over everything except an in-flight read, which returns pre-clear data.
        if (clear_i) begin
            state_d  = ST_IDLE;
            cycle_d  = '0;
            instr_d  = '0;
            branch_d = '0;
            mispr_d  = '0;
            hi_d     = 32'd0;
        end

        frozen_d = (state_d == ST_FROZEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cycle_q   <= '0;
            instr_q   <= '0;
            branch_q  <= '0;
            mispr_q   <= '0;
            hi_q      <= 32'd0;
            frozen_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            branch_q  <= branch_d;
            mispr_q   <= mispr_d;
            hi_q      <= hi_d;
            frozen_q  <= frozen_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_ack_o  = rd_ack_q;
    assign rd_data_o = rd_data_q;
    assign frozen_o  = frozen_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb/tb_perf_counter_unit.sv - table-driven bench for perf_counter_unit
module tb_perf_counter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i, clear_i, mispredict_i, wfi_i, rd_req_i;
    logic [1:0]  commit_cnt_i, branch_cnt_i;
    logic [2:0]  rd_addr_i;
    logic        rd_ack_o, frozen_o;
    logic [31:0] rd_data_o;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    perf_counter_unit #(.CYC_W(64), .EVT_W(20), .COMMIT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .commit_cnt_i (commit_cnt_i),
        .branch_cnt_i (branch_cnt_i),
        .mispredict_i (mispredict_i),
        .wfi_i        (wfi_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_ack_o     (rd_ack_o),
        .rd_data_o    (rd_data_o),
        .frozen_o     (frozen_o)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic [1:0]  commit;
        logic [1:0]  branch;
        logic        mis;
        logic        wfi;
        int          ncyc;
        logic [2:0]  addr;
        logic [31:0] exp;
        logic        exp_frz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic [1:0] cm,
                        input logic [1:0] br, input logic mi, input logic wf, input int n);
        enable_i = en; clear_i = clr; commit_cnt_i = cm; branch_cnt_i = br;
        mispredict_i = mi; wfi_i = wf;
        repeat (n) @(negedge clk);
        enable_i = 0; clear_i = 0; commit_cnt_i = 0; branch_cnt_i = 0;
        mispredict_i = 0; wfi_i = 0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        int n;
        n = 0;
        rd_req_i = 1; rd_addr_i = a;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_ack_o && n < 8);
        if (!rd_ack_o) begin
            nvec++; nfail++;
            $display("FAIL read_timeout: no ack for addr %0d within 8 cycles", a);
        end
        d = rd_data_o;
        rd_req_i = 0;
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        check(name, 64'(d), 64'(exp));
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 0; enable_i = 0; clear_i = 0; commit_cnt_i = 0; branch_cnt_i = 0;
        mispredict_i = 0; wfi_i = 0; rd_req_i = 0; rd_addr_i = 0;

        //       en clr cm br mi wf ncyc addr exp frz
        vecs.push_back('{1, 0, 2, 0, 0, 0,  1, 5, 32'd1,  0});
        vecs.push_back('{1, 0, 2, 0, 0, 0, 10, 0, 32'd10, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 2, 32'd20, 0});
        vecs.push_back('{1, 0, 0, 1, 1, 0,  5, 3, 32'd5,  0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 4, 32'd5,  0});
        vecs.push_back('{0, 0, 1, 0, 0, 0,  3, 2, 32'd20, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 0, 34, 0, 32'd49, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 1,  1, 0, 32'd50, 1});
        vecs.push_back('{1, 0, 2, 2, 1, 0,  5, 2, 32'd55, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 32'd50, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 5, 32'd6,  1});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 3, 32'd5,  1});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 6, 32'd0,  1});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 7, 32'd0,  1});
        vecs.push_back('{0, 1, 0, 0, 0, 0,  1, 5, 32'd0,  0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 2, 32'd0,  0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 32'd0,  0});

        repeat (2) @(negedge clk);
        check("reset_ack", 64'(rd_ack_o), 64'd0);
        check("reset_data", 64'(rd_data_o), 64'd0);
        check("reset_frozen", 64'(frozen_o), 64'd0);
        rst_n = 1;
        @(negedge clk);
        read_check("reset_status", 3'd5, 32'd0);
        read_check("reset_cycle", 3'd0, 32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].commit, vecs[i].branch,
                 vecs[i].mis, vecs[i].wfi, vecs[i].ncyc);
            read_check($sformatf("vec%0d_data", i), vecs[i].addr, vecs[i].exp);
            check($sformatf("vec%0d_frozen", i), 64'(frozen_o), 64'(vecs[i].exp_frz));
        end

        // Saturation of instr near 2^20-1
        step(1, 0, 0, 0, 0, 0, 1);
        force dut.instr_q = 20'hFFFFE;
        #1 release dut.instr_q;
        step(1, 0, 2, 0, 0, 0, 1);
        read_check("sat_first", 3'd2, 32'h000F_FFFF);
        step(1, 0, 2, 0, 0, 0, 3);
        read_check("sat_hold", 3'd2, 32'h000F_FFFF);

        // Coherent 64-bit read through hi_shadow
        step(0, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        force dut.cycle_q = 64'h1_FFFF_FFFF;
        #1 release dut.cycle_q;
        read_check("hi_lo_read", 3'd0, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 0, 0, 5);
        read_check("hi_shadow", 3'd1, 32'h1);
        read_check("lo_live", 3'd0, 32'h4);
        read_check("hi_relatched", 3'd1, 32'h2);

        // Held request: ack every other cycle, data only while ack
        step(0, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 4);
        rd_req_i = 1; rd_addr_i = 3'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("held_ack%0d", i), 64'(rd_ack_o), (i % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("held_data%0d", i), 64'(rd_data_o), (i % 2 == 0) ? 64'd3 : 64'd0);
        end
        rd_req_i = 0;
        @(negedge clk);

        // Clear + WFI + read in the same RUN cycle
        enable_i = 1; clear_i = 1; wfi_i = 1; commit_cnt_i = 2;
        rd_req_i = 1; rd_addr_i = 3'd0;
        @(negedge clk);
        enable_i = 0; clear_i = 0; wfi_i = 0; commit_cnt_i = 0; rd_req_i = 0;
        check("clr_ack", 64'(rd_ack_o), 64'd1);
        check("clr_old_data", 64'(rd_data_o), 64'd3);
        check("clr_frozen", 64'(frozen_o), 64'd0);
        @(negedge clk);
        read_check("clr_status", 3'd5, 32'd0);
        read_check("clr_cycle", 3'd0, 32'd0);
        read_check("clr_branch", 3'd3, 32'd0);
        read_check("clr_instr", 3'd2, 32'd0);

        // Asynchronous reset drops an outstanding ack immediately
        rd_req_i = 1; rd_addr_i = 3'd5;
        @(posedge clk);
        #2;
        check("midread_ack_before", 64'(rd_ack_o), 64'd1);
        rst_n = 0;
        #1;
        check("midread_ack_after", 64'(rd_ack_o), 64'd0);
        check("midread_data_after", 64'(rd_data_o), 64'd0);
        rd_req_i = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
